instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: address assigned to the first instruction after reset or restart.
REQ-002 SHALL have parameter DEPTH, default 2: output buffer entries; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 restart  input  1  synchronous; empties the buffer and sets next address to BASE_ADDR.
REQ-006 in_valid  input  1  field set present.
REQ-007 in_ready  output  1  encoder can accept a field set.
REQ-008 fmt  input  3  format select: 0 R, 1 I-load, 2 I-imm, 3 S, 4 B, 5 JAL, 6 LUI, 7 AUIPC.
REQ-009 rd, rs1, rs2  input  5 each  register indices.
REQ-010 func3  input  3; alt  input  1  (instruction bit 30 for R-type).
REQ-011 imm  input  32  signed byte immediate; U-type carries the final upper value.
REQ-012 out_valid  output  1; out_ready  input  1; out_instr  output  32; out_addr  output  32.
REQ-013 err  output  1  one-cycle rejection pulse; err_count  output  8  saturating rejection count.

Function
REQ-014 Opcodes SHALL be: R 0110011, I-load 0000011, I-imm 0010011, S 0100011, B 1100011, JAL 1101111, LUI 0110111, AUIPC 0010111.
REQ-015 R SHALL encode {0,alt,00000,rs2,rs1,func3,rd,op}.
REQ-016 I-load and I-imm SHALL encode {imm[11:0],rs1,func3,rd,op}.
REQ-017 S SHALL encode {imm[11:5],rs2,rs1,func3,imm[4:0],op}.
REQ-018 B SHALL encode {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],op}.
REQ-019 LUI and AUIPC SHALL encode {imm[31:12],rd,op}.
REQ-020 JAL SHALL encode {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-021 Range checks SHALL apply per format:
- I/S: imm equals sign-extension of imm[11:0].
- B: imm equals sign-extension of imm[12:0] and imm[0]=0.
- JAL: imm equals sign-extension of imm[20:0] and imm[0]=0.
- U: imm[11:0]=0.
- R: no check.
REQ-022 Accept occurs when in_valid and in_ready are both high on a clock edge.
REQ-023 An accepted set failing REQ-021 SHALL NOT be buffered and SHALL NOT advance the address.
- err high the following cycle for exactly one cycle.
- err_count increments and saturates at 255.
REQ-024 An accepted passing set SHALL be written to the buffer with out_addr equal to the current next address; next address then increments by 4 and wraps modulo 2^32.
REQ-025 Latency: out_valid SHALL be high no earlier than the cycle after the accepting edge when the buffer was empty, with no combinational path from in_* to out_*.
REQ-026 Buffer SHALL be FIFO-ordered; in_ready = (occupancy < DEPTH) and SHALL NOT depend on out_ready.
REQ-027 Pop occurs when out_valid and out_ready are both high; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-028 out_instr and out_addr SHALL stay stable while out_valid is high and out_ready is low.
REQ-029 restart SHALL have priority over a same-cycle accept or pop.
- The accept is discarded without error.
- err_count is retained.
REQ-030 Occupancy SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-031 During reset, outputs SHALL be: out_valid=0, err=0, err_count=0, in_ready=0, out_instr=0, out_addr=0.
REQ-032 After reset, next address SHALL be BASE_ADDR and the buffer empty.
REQ-033 in_ready SHALL rise on the first clock edge after reset deasserts.
REQ-034 Reset asserted mid-transfer SHALL discard all buffered entries immediately.

Verification
REQ-035 Scenario: R fmt=0, rd=3, rs1=1, rs2=2, func3=0, alt=1 -> out_instr 32'h402081B3, out_addr 0x0.
REQ-036 Scenario: I-imm rd=5, rs1=0, func3=0, imm=-1, then JAL rd=1, imm=8 -> 32'hFFF00293 at 0x0, then 32'h008000EF at 0x4.
REQ-037 Scenario: B imm=3, then I-imm imm=2048 -> two err pulses, err_count=2, no outputs, next valid instruction at address 0x0.
REQ-038 Scenario: out_ready held low with DEPTH=2 -> in_ready low after 2 accepts; release -> FIFO order preserved; same-cycle push/pop keeps occupancy.
REQ-039 Scenario: restart asserted with 2 entries buffered and in_valid high -> out_valid 0 next cycle, next instruction at BASE_ADDR, no err.
REQ-040 Scenario: reset asserted mid-stream between clock edges -> outputs zero immediately; err_count saturation checked at 255 after 300 rejects.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into 32-bit machine words.
// Each word is tagged with a sequential address and queued in a small FIFO.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   restart         synchronous flush; next address returns to BASE_ADDR
//   in_valid/ready  field-set handshake; ready is (occupancy < DEPTH)
//   fmt, rd, rs1, rs2, func3, alt, imm   instruction fields
//   out_valid/ready output handshake; out_instr/out_addr come from the FIFO head
//   err             one-cycle pulse after a field set fails its range check
//   err_count       saturating count of rejected field sets
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  func3,
    input  logic        alt,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned EW = 64;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Entry layout: {instr, addr}; entry 0 is the head and drives the outputs.
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_n [DEPTH];
    logic [CW-1:0] cnt_q, cnt_n;
    logic [31:0]   addr_q, addr_n;
    logic          in_ready_q, out_valid_q, err_q;
    logic [7:0]    err_count_q;

    logic [31:0] enc_c;
    logic        ok_c;
    logic        accept, push, pop, reject;

    // Range checks: immediate must fit its encoded field exactly.
    logic fit12, fit13, fit21, u_low_zero;
    assign fit12      = (imm == {{20{imm[11]}}, imm[11:0]});
    assign fit13      = (imm == {{19{imm[12]}}, imm[12:0]}) && !imm[0];
    assign fit21      = (imm == {{11{imm[20]}}, imm[20:0]}) && !imm[0];
    assign u_low_zero = (imm[11:0] == 12'd0);

    // Field packing per format.
    always_comb begin
        enc_c = '0;
        ok_c  = 1'b1;
        case (fmt)
            3'd0: enc_c = {1'b0, alt, 5'b00000, rs2, rs1, func3, rd, OP_R};
            3'd1: begin
                enc_c = {imm[11:0], rs1, func3, rd, OP_LOAD};
                ok_c  = fit12;
            end
            3'd2: begin
                enc_c = {imm[11:0], rs1, func3, rd, OP_IMM};
                ok_c  = fit12;
            end
            3'd3: begin
                enc_c = {imm[11:5], rs2, rs1, func3, imm[4:0], OP_STORE};
                ok_c  = fit12;
            end
            3'd4: begin
                enc_c = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], OP_BR};
                ok_c  = fit13;
            end
            3'd5: begin
                enc_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                ok_c  = fit21;
            end
            3'd6: begin
                enc_c = {imm[31:12], rd, OP_LUI};
                ok_c  = u_low_zero;
            end
            3'd7: begin
                enc_c = {imm[31:12], rd, OP_AUIPC};
                ok_c  = u_low_zero;
            end
        endcase
    end

    // Restart overrides any same-cycle accept or pop.
    assign accept = in_valid && in_ready_q;
    assign push   = accept && ok_c && !restart;
    assign reject = accept && !ok_c && !restart;
    assign pop    = out_valid_q && out_ready && !restart;

    // Shift-register FIFO: a pop shifts toward the head, a push lands just past the last entry.
    always_comb begin
        mem_n  = mem_q;
        cnt_n  = cnt_q;
        addr_n = addr_q;
        if (restart) begin
            cnt_n  = '0;
            addr_n = BASE_ADDR;
        end else begin
            if (pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    mem_n[i] = mem_q[i + 1];
                end
                cnt_n = cnt_q - CW'(1);
            end
            if (push) begin
                mem_n[IW'(cnt_n)] = {enc_c, addr_q};
                cnt_n             = cnt_n + CW'(1);
                addr_n            = addr_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            cnt_q       <= '0;
            addr_q      <= BASE_ADDR;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            mem_q       <= mem_n;
            cnt_q       <= cnt_n;
            addr_q      <= addr_n;
            in_ready_q  <= (cnt_n < CW'(DEPTH));
            out_valid_q <= (cnt_n != '0);
            err_q       <= reject;
            if (reject && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = mem_q[0][63:32];
    assign out_addr  = mem_q[0][31:0];
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scenarios plus randomized traffic for instr_encoder,
// checked against a queue-based reference model.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, restart, in_valid, in_ready, alt, out_valid, out_ready, err;
    logic [2:0]  fmt, func3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, out_instr, out_addr;
    logic [7:0]  err_count;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .alt(alt), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] q[$];
    logic [31:0] m_addr;
    logic        m_ready, m_err;
    int          m_cnt;

    // Returns {ok, instr} computed from field arithmetic.
    function automatic logic [32:0] model_enc(input logic [2:0] f, input logic [4:0] d,
                                              input logic [4:0] s1, input logic [4:0] s2,
                                              input logic [2:0] f3, input logic a,
                                              input logic [31:0] im);
        int signed   v;
        logic [31:0] w, rdv, r1v, r2v, f3v;
        logic        ok;
        v   = $signed(im);
        rdv = 32'(d) << 7;
        r1v = 32'(s1) << 15;
        r2v = 32'(s2) << 20;
        f3v = 32'(f3) << 12;
        ok  = 1'b1;
        w   = 32'd0;
        case (f)
            3'd0: w = (a ? 32'h4000_0000 : 32'd0) | r2v | r1v | f3v | rdv | 32'h33;
            3'd1, 3'd2: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = ((im & 32'hFFF) << 20) | r1v | f3v | rdv | ((f == 3'd1) ? 32'h03 : 32'h13);
            end
            3'd3: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = (((im >> 5) & 32'h7F) << 25) | r2v | r1v | f3v | ((im & 32'h1F) << 7) | 32'h23;
            end
            3'd4: begin
                ok = (v >= -4096) && (v <= 4095) && ((im & 32'd1) == 32'd0);
                w  = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2v | r1v | f3v
                   | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'd1) << 7) | 32'h63;
            end
            3'd5: begin
                ok = (v >= -1048576) && (v <= 1048575) && ((im & 32'd1) == 32'd0);
                w  = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                   | (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'hFF) << 12) | rdv | 32'h6F;
            end
            default: begin
                ok = ((im & 32'hFFF) == 32'd0);
                w  = (im & 32'hFFFF_F000) | rdv | ((f == 3'd6) ? 32'h37 : 32'h17);
            end
        endcase
        return {ok, w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_addr  = BASE;
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("err", 32'(err), 32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        if (q.size() > 0) begin
            chk("out_instr", out_instr, q[0][63:32]);
            chk("out_addr", out_addr, q[0][31:0]);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic step();
        logic        acc, pp;
        logic [32:0] e;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            acc   = in_valid && m_ready;
            pp    = (q.size() > 0) && out_ready;
            m_err = 1'b0;
            if (restart) begin
                q.delete();
                m_addr = BASE;
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) begin
                    e = model_enc(fmt, rd, rs1, rs2, func3, alt, imm);
                    if (e[32]) begin
                        q.push_back({e[31:0], m_addr});
                        m_addr = m_addr + 32'd4;
                    end else begin
                        m_err = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end
            m_ready = (q.size() < DEPTH);
        end
        #1;
        check_outputs();
    endtask

    task automatic set_in(input logic v, input logic [2:0] f, input logic [4:0] d,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                          input logic a, input logic [31:0] im);
        in_valid = v; fmt = f; rd = d; rs1 = s1; rs2 = s2; func3 = f3; alt = a; imm = im;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        int signed t;
        case ($urandom_range(0, 3))
            0: t = int'($urandom_range(0, 8191)) - 4096;
            1: t = int'($urandom);
            2: t = int'($urandom & 32'hFFFF_F000);
            default: t = int'($urandom_range(0, 4194303)) - 2097152;
        endcase
        return 32'(t);
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_instr"}, out_instr, 32'd0);
        chk({tag, "_out_addr"}, out_addr, 32'd0);
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
        model_reset();

        // Reset state, then in_ready rises on the first edge after release
        step();
        step();
        check_zero_outputs("reset");
        reset = 1'b0;
        #1;
        chk("ready_before_edge", 32'(in_ready), 32'd0);
        step();
        chk("ready_after_edge", 32'(in_ready), 32'd1);

        // R-type known vector
        set_in(1'b1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
        step();
        in_valid = 1'b0;
        chk("r_instr", out_instr, 32'h402081B3);
        chk("r_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        step();

        // I-imm then JAL
        do_restart();
        out_ready = 1'b0;
        set_in(1'b1, 3'd2, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_FFFF);
        step();
        set_in(1'b1, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8);
        step();
        in_valid = 1'b0;
        chk("iimm_instr", out_instr, 32'hFFF00293);
        chk("iimm_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        step();
        chk("jal_instr", out_instr, 32'h008000EF);
        chk("jal_addr", out_addr, 32'h4);
        step();

        // Two range rejections leave the address untouched
        do_restart();
        set_in(1'b1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3);
        step();
        chk("rej1_err", 32'(err), 32'd1);
        set_in(1'b1, 3'd2, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd2048);
        step();
        in_valid = 1'b0;
        chk("rej2_err", 32'(err), 32'd1);
        chk("rej_count", 32'(err_count), 32'd2);
        chk("rej_no_out", 32'(out_valid), 32'd0);
        step();
        chk("rej_err_drop", 32'(err), 32'd0);
        set_in(1'b1, 3'd2, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd5);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("after_rej_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        step();

        // Back-pressure: fill, stall, then drain with overlapping push/pop
        do_restart();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 3'd0, 5'(i + 1), 5'(i), 5'(i + 2), 3'(i), 1'b0, 32'd0);
            step();
        end
        chk("full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        set_in(1'b1, 3'd0, 5'd9, 5'd8, 5'd7, 3'd1, 1'b1, 32'd0);
        step();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Restart with two entries buffered and in_valid high
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 3'd6, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000);
            step();
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_valid", 32'(out_valid), 32'd0);
        chk("restart_err", 32'(err), 32'd0);
        set_in(1'b1, 3'd7, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCD_E000);
        step();
        in_valid = 1'b0;
        chk("restart_addr", out_addr, BASE);
        out_ready = 1'b1;
        step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 5'($urandom),
                   5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), rand_imm());
            out_ready = ($urandom_range(0, 2) != 0);
            restart   = ($urandom_range(0, 39) == 0);
            step();
        end
        restart = 1'b0;

        // Rejection counter saturation
        out_ready = 1'b1;
        set_in(1'b1, 3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
        for (int n = 0; n < 300; n++) step();
        in_valid = 1'b0;
        chk("err_sat", 32'(err_count), 32'd255);
        step();

        // Reset between clock edges with entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 3'd2, 5'd2, 5'd3, 5'd0, 3'd4, 1'b0, 32'(i + 10));
            step();
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_zero_outputs("midreset");
        step();
        reset = 1'b0;
        step();
        chk("post_reset_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
